// File: rtl/tlul_device_adapter.sv
// TL-UL device adapter: terminates a TL-UL host channel and drives a
// req/gnt/rvalid memory port, answering in order with AccessAck(Data).
//
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   tl_i / tl_o       TL-UL A channel in (plus d_ready), D channel out (plus a_ready)
//   req_o, gnt_i      memory request / grant handshake
//   we_o, addr_o      write enable and byte address
//   wdata_o, be_o     write data and byte enables
//   rvalid_i          memory response strobe, one per grant, in order
//   rdata_i, rerror_i response data and error, qualified by rvalid_i

package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_device_adapter
    import tlul_pkg::*;
#(
    parameter int AW          = 32,
    parameter int Outstanding = 2,
    parameter bit ErrOnWrite  = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    input  tl_h2d_t       tl_i,
    output tl_d2h_t       tl_o,
    output logic          req_o,
    input  logic          gnt_i,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [31:0]   wdata_o,
    output logic [3:0]    be_o,
    input  logic          rvalid_i,
    input  logic [31:0]   rdata_i,
    input  logic          rerror_i
);

    localparam int PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
    localparam int CntW = $clog2(Outstanding + 1);

    localparam logic [CntW-1:0] MaxCnt  = CntW'(Outstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Outstanding - 1);

    typedef struct packed {
        logic       is_get;
        logic [1:0] size;
        logic [7:0] source;
        logic       err;
    } trk_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        rerror;
    } dat_t;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Request check
    // ------------------------------------------------------------------
    logic       is_put;
    logic       is_get;
    logic       bad_op;
    logic       bad_size;
    logic       misalign;
    logic       bad_mask;
    logic [3:0] lane_mask;
    logic       err_a;

    always_comb begin
        lane_mask = 4'hF;
        misalign  = 1'b0;
        unique case (tl_i.a_size)
            2'd0: begin
                lane_mask = 4'b0001 << tl_i.a_address[1:0];
            end
            2'd1: begin
                lane_mask = tl_i.a_address[1] ? 4'b1100 : 4'b0011;
                misalign  = tl_i.a_address[0];
            end
            default: begin
                lane_mask = 4'hF;
                misalign  = |tl_i.a_address[1:0];
            end
        endcase
    end

    assign is_put   = (tl_i.a_opcode == PutFullData)
                    | (tl_i.a_opcode == PutPartialData);
    assign is_get   = (tl_i.a_opcode == Get);
    assign bad_op   = ~(is_put | is_get);
    assign bad_size = (tl_i.a_size == 2'd3);

    // Full writes must hit exactly the addressed lanes; partial writes
    // may use any subset of them. Reads ignore the mask entirely.
    assign bad_mask =
        ((tl_i.a_opcode == PutFullData) & (tl_i.a_mask != lane_mask)) |
        ((tl_i.a_opcode == PutPartialData) & |(tl_i.a_mask & ~lane_mask));

    assign err_a = bad_op | bad_size | misalign | bad_mask
                 | (ErrOnWrite & is_put);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] trk_wptr_q, trk_wptr_d;
    logic [PtrW-1:0] trk_rptr_q, trk_rptr_d;
    trk_t            trk_mem_q [Outstanding];
    trk_t            trk_mem_d [Outstanding];

    logic [CntW-1:0] dat_cnt_q, dat_cnt_d;
    logic [PtrW-1:0] dat_wptr_q, dat_wptr_d;
    logic [PtrW-1:0] dat_rptr_q, dat_rptr_d;
    dat_t            dat_mem_q [Outstanding];
    dat_t            dat_mem_d [Outstanding];

    // ------------------------------------------------------------------
    // A channel / memory port
    // ------------------------------------------------------------------
    logic room;
    logic a_ready;
    logic accept;
    trk_t trk_in;

    // Not pop-aware: a full tracker blocks even on a same-cycle D pop.
    assign room    = (count_q < MaxCnt);
    assign a_ready = ~reset & room & (err_a | gnt_i);
    assign accept  = tl_i.a_valid & a_ready;

    assign req_o   = ~reset & tl_i.a_valid & ~err_a & room;
    assign we_o    = is_put;
    assign addr_o  = tl_i.a_address[AW-1:0];
    assign wdata_o = tl_i.a_data;
    assign be_o    = is_put ? tl_i.a_mask : 4'hF;

    assign trk_in = '{
        is_get: is_get,
        size:   tl_i.a_size,
        source: tl_i.a_source,
        err:    err_a
    };

    // ------------------------------------------------------------------
    // D channel, driven from registered FIFO heads
    // ------------------------------------------------------------------
    trk_t trk_head;
    dat_t dat_head;
    logic d_valid;
    logic d_hs;
    logic dat_push;
    logic dat_pop;

    assign trk_head = trk_mem_q[trk_rptr_q];
    assign dat_head = dat_mem_q[dat_rptr_q];

    assign d_valid  = ~reset & (count_q != '0)
                    & (trk_head.err | (dat_cnt_q != '0));
    assign d_hs     = d_valid & tl_i.d_ready;

    // Errored entries never reached memory, so they own no data slot.
    assign dat_push = rvalid_i & ~reset;
    assign dat_pop  = d_hs & ~trk_head.err;

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready;
        tl_o.d_valid  = d_valid;
        tl_o.d_opcode = trk_head.is_get ? AccessAckData : AccessAck;
        tl_o.d_size   = trk_head.size;
        tl_o.d_source = trk_head.source;
        tl_o.d_data   = (trk_head.is_get & ~trk_head.err)
                      ? dat_head.rdata : 32'h0;
        tl_o.d_error  = trk_head.err | (~trk_head.err & dat_head.rerror);
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        unique case ({accept, d_hs})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        trk_wptr_d = trk_wptr_q;
        trk_rptr_d = trk_rptr_q;
        trk_mem_d  = trk_mem_q;
        if (accept) begin
            trk_mem_d[trk_wptr_q] = trk_in;
            trk_wptr_d = ptr_inc(trk_wptr_q);
        end
        if (d_hs) begin
            trk_rptr_d = ptr_inc(trk_rptr_q);
        end
    end

    always_comb begin
        dat_wptr_d = dat_wptr_q;
        dat_rptr_d = dat_rptr_q;
        dat_mem_d  = dat_mem_q;
        dat_cnt_d  = dat_cnt_q;
        if (dat_push) begin
            dat_mem_d[dat_wptr_q] = '{rdata: rdata_i, rerror: rerror_i};
            dat_wptr_d = ptr_inc(dat_wptr_q);
        end
        if (dat_pop) begin
            dat_rptr_d = ptr_inc(dat_rptr_q);
        end
        unique case ({dat_push, dat_pop})
            2'b10:   dat_cnt_d = dat_cnt_q + 1'b1;
            2'b01:   dat_cnt_d = dat_cnt_q - 1'b1;
            default: dat_cnt_d = dat_cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q    <= '0;
            trk_wptr_q <= '0;
            trk_rptr_q <= '0;
            dat_cnt_q  <= '0;
            dat_wptr_q <= '0;
            dat_rptr_q <= '0;
        end else begin
            count_q    <= count_d;
            trk_wptr_q <= trk_wptr_d;
            trk_rptr_q <= trk_rptr_d;
            dat_cnt_q  <= dat_cnt_d;
            dat_wptr_q <= dat_wptr_d;
            dat_rptr_q <= dat_rptr_d;
        end
    end

    // Storage needs no reset: entries are only read behind valid counts.
    always_ff @(posedge clock) begin
        trk_mem_q <= trk_mem_d;
        dat_mem_q <= dat_mem_d;
    end

    logic unused_tl;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_address};

endmodule

// File: tb/tb_tlul_device_adapter.sv
// Testbench for tlul_device_adapter: directed scenarios then random
// traffic, checked each cycle against a transaction-level model.

module tb_tlul_device_adapter;
    import tlul_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        req_o, gnt_i, we_o;
    logic [31:0] addr_o, wdata_o;
    logic [3:0]  be_o;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic        rerror_i;

    tl_h2d_t     tl2_i;
    tl_d2h_t     tl2_o;
    logic        req2, we2;
    logic [31:0] addr2, wdata2;
    logic [3:0]  be2;
    logic        gnt2 = 1'b0;
    logic        rvalid2 = 1'b0;
    logic [31:0] rdata2 = 32'h0;
    logic        rerror2 = 1'b0;

    always #5 clk = ~clk;

    tlul_device_adapter #(
        .AW(32), .Outstanding(2), .ErrOnWrite(1'b0)
    ) u_dut (
        .clock(clk), .reset(rst), .tl_i(tl_i), .tl_o(tl_o),
        .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .be_o(be_o), .rvalid_i(rvalid_i),
        .rdata_i(rdata_i), .rerror_i(rerror_i)
    );

    tlul_device_adapter #(
        .AW(32), .Outstanding(2), .ErrOnWrite(1'b1)
    ) u_dut_ro (
        .clock(clk), .reset(rst), .tl_i(tl2_i), .tl_o(tl2_o),
        .req_o(req2), .gnt_i(gnt2), .we_o(we2), .addr_o(addr2),
        .wdata_o(wdata2), .be_o(be2), .rvalid_i(rvalid2),
        .rdata_i(rdata2), .rerror_i(rerror2)
    );

    typedef struct {
        bit          get;
        logic [1:0]  size;
        logic [7:0]  src;
        bit          err;
        bit          has;
        logic [31:0] data;
        bit          rerr;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          rerr;
    } mresp_t;

    exp_t        q[$];
    mresp_t      mq[$];
    logic [31:0] mem [logic [29:0]];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit gnt_rand = 0;
    bit rerr_en  = 0;
    int lat_min  = 0;
    int lat_max  = 0;
    bit last_acc = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] lanes_of(logic [1:0] sz, logic [31:0] a);
        int nb;
        int l;
        nb = 1 << sz;
        l  = ((1 << nb) - 1) << (a % 4);
        return l[3:0];
    endfunction

    function automatic bit model_err(logic [2:0] op, logic [1:0] sz,
                                     logic [31:0] a, logic [3:0] m,
                                     bit eow);
        bit put;
        logic [3:0] ln;
        put = (op == 3'd0) || (op == 3'd1);
        if (!(put || op == 3'd4)) return 1;
        if (sz > 2) return 1;
        if ((a % (1 << sz)) != 0) return 1;
        ln = lanes_of(sz, a);
        if (op == 3'd0 && m != ln) return 1;
        if (op == 3'd1 && (m & ~ln) != 4'h0) return 1;
        if (eow && put) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] rd(logic [29:0] w);
        return mem.exists(w) ? mem[w] : {2'b10, w};
    endfunction

    // One clock cycle: drive memory side, check outputs, advance model.
    task automatic tick();
        bit     err, room, exp_req, exp_ar, exp_dv, gr, hs;
        exp_t   e;
        mresp_t m;
        logic [31:0] w;
        if (rst) begin
            rvalid_i = 1'b1;
            rdata_i  = 32'hBAD0_BAD0;
            rerror_i = 1'b1;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            rvalid_i = 1'b1;
            rdata_i  = mq[0].data;
            rerror_i = mq[0].rerr;
        end else begin
            rvalid_i = 1'b0;
            rdata_i  = $urandom;
            rerror_i = 1'($urandom_range(0, 1));
        end
        gnt_i = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        err = model_err(tl_i.a_opcode, tl_i.a_size, tl_i.a_address,
                        tl_i.a_mask, 0);
        room    = q.size() < 2;
        exp_req = !rst && tl_i.a_valid && !err && room;
        exp_ar  = !rst && room && (err || gnt_i);
        exp_dv  = !rst && q.size() > 0 && (q[0].err || q[0].has);
        check("req_o", 32'(req_o), 32'(exp_req));
        check("a_ready", 32'(tl_o.a_ready), 32'(exp_ar));
        check("d_valid", 32'(tl_o.d_valid), 32'(exp_dv));
        if (exp_req) begin
            check("we_o", 32'(we_o), 32'(tl_i.a_opcode != 3'd4));
            check("be_o", 32'(be_o),
                  (tl_i.a_opcode == 3'd4) ? 32'hF : 32'(tl_i.a_mask));
            check("addr_o", addr_o, tl_i.a_address);
            check("wdata_o", wdata_o, tl_i.a_data);
        end
        if (exp_dv) begin
            e = q[0];
            check("d_opcode", 32'(tl_o.d_opcode), e.get ? 32'd1 : 32'd0);
            check("d_size", 32'(tl_o.d_size), 32'(e.size));
            check("d_source", 32'(tl_o.d_source), 32'(e.src));
            check("d_error", 32'(tl_o.d_error), 32'(e.err || e.rerr));
            check("d_data", tl_o.d_data,
                  (e.err || !e.get) ? 32'h0 : e.data);
            check("d_param", 32'(tl_o.d_param), 32'h0);
        end
        if (rst) begin
            q.delete();
            mq.delete();
            last_acc = 0;
        end else begin
            last_acc = tl_i.a_valid && exp_ar;
            gr = exp_req && gnt_i;
            hs = exp_dv && tl_i.d_ready;
            if (hs) void'(q.pop_front());
            if (rvalid_i) begin
                void'(mq.pop_front());
                foreach (q[i]) begin
                    if (!q[i].err && !q[i].has) begin
                        q[i].has  = 1;
                        q[i].data = rdata_i;
                        q[i].rerr = rerror_i;
                        break;
                    end
                end
            end
            if (last_acc) begin
                e.get  = (tl_i.a_opcode == 3'd4);
                e.size = tl_i.a_size;
                e.src  = tl_i.a_source;
                e.err  = err;
                e.has  = 0;
                e.data = 32'h0;
                e.rerr = 0;
                q.push_back(e);
            end
            if (gr) begin
                w = rd(tl_i.a_address[31:2]);
                if (tl_i.a_opcode == 3'd4) begin
                    m.data = w;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (tl_i.a_mask[b]) w[8*b +: 8] = tl_i.a_data[8*b +: 8];
                    mem[tl_i.a_address[31:2]] = w;
                    m.data = 32'h0;
                end
                m.rerr = rerr_en && ($urandom_range(0, 7) == 0);
                m.due  = cyc + 1 + int'($urandom_range(lat_min, lat_max));
                mq.push_back(m);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_a(logic [2:0] op, logic [1:0] sz, logic [31:0] a,
                         logic [3:0] m, logic [31:0] d, logic [7:0] src);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_size    = sz;
        tl_i.a_address = a;
        tl_i.a_mask    = m;
        tl_i.a_data    = d;
        tl_i.a_source  = src;
    endtask

    task automatic wait_acc();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 40);
        if (!last_acc) begin
            n_tests++;
            n_fail++;
            $error("FAIL accept_timeout: observed no accept expected accept");
        end
    endtask

    task automatic put_req(logic [2:0] op, logic [1:0] sz, logic [31:0] a,
                           logic [3:0] m, logic [31:0] d, logic [7:0] src);
        set_a(op, sz, a, m, d, src);
        wait_acc();
    endtask

    task automatic idle(int n);
        tl_i.a_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        logic [2:0]  op;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [3:0]  m;
        int          pick;

        rst   = 1'b1;
        tl_i  = '0;
        tl2_i = '0;
        tl_i.d_ready  = 1'b1;
        tl2_i.d_ready = 1'b1;
        set_a(3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd1);
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        tl_i.a_valid = 1'b0;
        mem[30'h4] = 32'hDEAD_BEEF;

        // Read with one-cycle memory latency
        put_req(3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd3);
        idle(4);

        // Partial write of the upper halfword, then read it back
        put_req(3'd1, 2'd1, 32'h6, 4'b1100, 32'hAABB_0000, 8'd5);
        idle(4);
        put_req(3'd4, 2'd2, 32'h4, 4'h0, 32'h0, 8'd6);
        idle(4);

        // Misaligned read answered locally
        put_req(3'd4, 2'd2, 32'h2, 4'hF, 32'h0, 8'd7);
        idle(3);

        // Full tracker under D backpressure
        tl_i.d_ready = 1'b0;
        put_req(3'd4, 2'd2, 32'h20, 4'hF, 32'h0, 8'd0);
        put_req(3'd4, 2'd2, 32'h24, 4'hF, 32'h0, 8'd1);
        set_a(3'd4, 2'd2, 32'h28, 4'hF, 32'h0, 8'd2);
        repeat (4) tick();
        tl_i.d_ready = 1'b1;
        wait_acc();
        idle(6);

        // Errored request queued behind a slow read
        lat_min = 3;
        lat_max = 3;
        put_req(3'd4, 2'd2, 32'h30, 4'hF, 32'h0, 8'd10);
        put_req(3'd3, 2'd2, 32'h34, 4'hF, 32'h0, 8'd11);
        put_req(3'd4, 2'd2, 32'h38, 4'hF, 32'h0, 8'd12);
        idle(12);

        // Reset with two reads in flight
        lat_min = 5;
        lat_max = 5;
        put_req(3'd4, 2'd2, 32'h40, 4'hF, 32'h0, 8'd20);
        put_req(3'd4, 2'd2, 32'h44, 4'hF, 32'h0, 8'd21);
        idle(1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lat_min = 0;
        lat_max = 0;
        idle(3);
        put_req(3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd22);
        idle(4);

        // Read-only instance: writes error locally, reads go to memory
        tl2_i.a_valid   = 1'b1;
        tl2_i.a_opcode  = 3'd0;
        tl2_i.a_size    = 2'd2;
        tl2_i.a_address = 32'h40;
        tl2_i.a_mask    = 4'hF;
        tl2_i.a_data    = 32'h1234_5678;
        tl2_i.a_source  = 8'd9;
        #1;
        check("ro_req", 32'(req2), 32'h0);
        check("ro_a_ready", 32'(tl2_o.a_ready), 32'h1);
        tick();
        tl2_i.a_valid = 1'b0;
        #1;
        check("ro_d_valid", 32'(tl2_o.d_valid), 32'h1);
        check("ro_d_error", 32'(tl2_o.d_error), 32'h1);
        check("ro_d_opcode", 32'(tl2_o.d_opcode), 32'h0);
        check("ro_d_source", 32'(tl2_o.d_source), 32'd9);
        tick();
        #1;
        check("ro_d_idle", 32'(tl2_o.d_valid), 32'h0);
        tl2_i.a_valid  = 1'b1;
        tl2_i.a_opcode = 3'd4;
        #1;
        check("ro_get_req", 32'(req2), 32'h1);
        check("ro_get_a_ready", 32'(tl2_o.a_ready), 32'h0);
        tl2_i.a_valid = 1'b0;
        tick();

        // Random traffic
        gnt_rand = 1;
        rerr_en  = 1;
        lat_min  = 0;
        lat_max  = 4;
        tl_i.a_valid = 1'b0;
        for (int it = 0; it < 1500; it++) begin
            tl_i.d_ready = ($urandom_range(0, 3) != 0);
            if (!tl_i.a_valid || last_acc) begin
                pick = $urandom_range(0, 9);
                if (pick < 4)       op = 3'd4;
                else if (pick < 6)  op = 3'd0;
                else if (pick < 8)  op = 3'd1;
                else if (pick == 8) op = 3'd3;
                else                op = 3'($urandom_range(5, 7));
                sz = ($urandom_range(0, 7) == 0) ? 2'd3
                                                 : 2'($urandom_range(0, 2));
                a = 32'($urandom_range(0, 15)) << 2;
                if ($urandom_range(0, 5) == 0 || sz == 2'd3)
                    a = a + 32'($urandom_range(0, 3));
                else
                    a = a + ((32'($urandom_range(0, 3)) >> sz) << sz);
                m = lanes_of(sz, a);
                if (op == 3'd1) m = m & 4'($urandom);
                if (op == 3'd4 || $urandom_range(0, 5) == 0)
                    m = 4'($urandom);
                set_a(op, sz, a, m, $urandom, 8'($urandom));
                tl_i.a_valid = ($urandom_range(0, 9) < 7);
            end
            tick();
        end

        gnt_rand     = 0;
        tl_i.d_ready = 1'b1;
        idle(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
